// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 32-bit combinational ALU.
// Round-robin grant over valid/ready channels, registered operands, and a single
// registered response channel tagged with the requester id.
// Optional build macro ALU_ARB_STATS_EN adds saturating per-requester grant
// counters (ports gnt_cnt0/gnt_cnt1, parameter CNT_W).

// Combinational 32-bit logic ALU: op 0=AND, 1=OR, 2=XOR, 3=NOR, others give Z=0.
module alu (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [3:0]  op_code,
  output logic [31:0] z,
  output logic        equal,
  output logic        overflow,
  output logic        zero
);

  // Result select by op code; flags derived from operands and result.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    z = '0;
    case (op_code)
      4'd0:    z = x & y;
      4'd1:    z = x | y;
      4'd2:    z = x ^ y;
      4'd3:    z = ~(x | y);
      default: z = '0;
    endcase
    equal    = (x == y);
    overflow = 1'b0;  // bitwise operations cannot overflow
    zero     = (z == '0);
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic [2:0]       rsp_flags,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  , output logic [CNT_W-1:0] gnt_cnt0
  , output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  logic             ptr;    // requester preferred when both are valid
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       op_q;
  logic             id_q;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] alu_z;
  logic             alu_eq;
  logic             alu_ov;
  logic             alu_zero;

  // Grant decision: only in IDLE and out of reset; a lone valid requester wins
  // regardless of the pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state == ST_IDLE) begin
      if (req0_valid && (!req1_valid || !ptr)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  alu u_alu (
    .x        (x_q),
    .y        (y_q),
    .op_code  (op_q),
    .z        (alu_z),
    .equal    (alu_eq),
    .overflow (alu_ov),
    .zero     (alu_zero)
  );

  // Control FSM with operand capture and registered response/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_z     <= '0;
      rsp_flags <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            x_q   <= gnt1 ? req1_x  : req0_x;
            y_q   <= gnt1 ? req1_y  : req0_y;
            op_q  <= gnt1 ? req1_op : req0_op;
            id_q  <= gnt1;
            ptr   <= gnt0;  // point at the requester that was not served
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_z     <= alu_z;
          rsp_flags <= {alu_eq, alu_ov, alu_zero};
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating grant counters, one step per accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (gnt1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule
